// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder; master drives the request, slave returns the result.
// Carries the ovf result bit only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (output start, a, b, cin, sub, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle add/sub, BITS_PER_CYCLE bits per clock LSB first; SERIAL_ADDER_OVF_EN adds signed ovf.
// done pulses WIDTH/BITS_PER_CYCLE+1 cycles after start is accepted; start is ignored unless IDLE.
module serial_adder #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave io_bus
);
  localparam int NSLICE = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WIDTH-1:0]      r_opa;
  logic [WIDTH-1:0]      r_opb;
  logic [WIDTH-1:0]      r_res;
  logic [WIDTH-1:0]      r_sum;
  logic                  r_carry;
  logic                  r_cout;
  logic [CNT_W-1:0]      r_cnt;
  logic [BITS_PER_CYCLE:0] w_slice;
  logic [WIDTH-1:0]      w_res_nxt;
  logic                  w_last;
  logic                  w_busy;
  logic                  w_done;

  assign w_slice = {1'b0, r_opa[BITS_PER_CYCLE-1:0]}
                 + {1'b0, r_opb[BITS_PER_CYCLE-1:0]}
                 + {{BITS_PER_CYCLE{1'b0}}, r_carry};
  assign w_last  = (r_cnt == LAST_CNT);

  // Result fills from the MSB end so the first (LSB) slice lands at bit 0 after the last shift.
  generate
    if (WIDTH == BITS_PER_CYCLE) begin : g_single
      assign w_res_nxt = w_slice[BITS_PER_CYCLE-1:0];
    end else begin : g_multi
      assign w_res_nxt = {w_slice[BITS_PER_CYCLE-1:0], r_res[WIDTH-1:BITS_PER_CYCLE]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: if (io_bus.start) w_state_nxt = S_RUN;
      S_RUN: begin
        w_busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == S_IDLE) begin
      if (io_bus.start) begin
        // Subtract as a + ~b + ~cin: invert b and fold sub into the initial carry.
        r_opa   <= io_bus.a;
        r_opb   <= io_bus.sub ? ~io_bus.b : io_bus.b;
        r_carry <= io_bus.cin ^ io_bus.sub;
        r_cnt   <= '0;
      end
    end else if (r_state == S_RUN) begin
      r_opa   <= r_opa >> BITS_PER_CYCLE;
      r_opb   <= r_opb >> BITS_PER_CYCLE;
      r_res   <= w_res_nxt;
      r_carry <= w_slice[BITS_PER_CYCLE];
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_sum  <= w_res_nxt;
        r_cout <= w_slice[BITS_PER_CYCLE];
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;
  logic w_ovf;

  // Carry into the MSB is recovered from the MSB sum bit: c_in = s ^ a ^ b.
  assign w_ovf = w_slice[BITS_PER_CYCLE] ^ w_slice[BITS_PER_CYCLE-1]
               ^ r_opa[BITS_PER_CYCLE-1] ^ r_opb[BITS_PER_CYCLE-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            r_ovf <= 1'b0;
    else if (r_state == S_RUN && w_last) r_ovf <= w_ovf;
  end

  assign io_bus.ovf = r_ovf;
`endif

  assign io_bus.busy = w_busy;
  assign io_bus.done = w_done;
  assign io_bus.sum  = r_sum;
  assign io_bus.cout = r_cout;
endmodule
